// File: rtl/regwb_arbiter_pkg.sv
// Shared types and defaults for the register write-back arbiter.
package regwb_arbiter_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 8;

   // Source encoding carried on mux_sel
   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   // Round-robin pointer: which requester wins the next contended cycle
   typedef enum logic {
      PRI_A = 1'b0,
      PRI_B = 1'b1
   } pri_e;

endpackage

// File: rtl/regwb_arbiter_rr_arb2.sv
// Two-way round-robin grant logic with a pointer FSM.
// Readiness is combinational from valid/stall/pointer; the pointer only
// moves on an actual grant, so a stalled or idle cycle keeps priority.
module rr_arb2
   import regwb_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic a_valid,
   input  logic b_valid,
   input  logic stall,
   output logic a_ready,
   output logic b_ready
);

   pri_e state_q, state_d;
   // Held low through reset and for the first edge after release, so no
   // grant can land on the release edge itself.
   logic armed_q, armed_d;

   // Pointer and arm flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PRI_A;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
      end
   end

   // Grant decode and next pointer: winner loses priority next time
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      state_d = state_q;
      armed_d = 1'b1;
      if (armed_q && !stall) begin
         if (a_valid && (!b_valid || state_q == PRI_A)) begin
            a_ready = 1'b1;
         end else if (b_valid) begin
            b_ready = 1'b1;
         end
      end
      if (a_ready) begin
         state_d = PRI_B;
      end else if (b_ready) begin
         state_d = PRI_A;
      end
   end

endmodule

// File: rtl/regwb_arbiter.sv
// Register-file write-back arbiter: ALU (A) vs load return (B).
// One-cycle registered write port plus a saturating contention counter.
module regwb_arbiter
   import regwb_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              stall,
   input  logic              clr_cnt,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              mux_sel,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_valid (a_valid),
      .b_valid (b_valid),
      .stall   (stall),
      .a_ready (a_ready),
      .b_ready (b_ready)
   );

   // Capture the granted request; writes to r0 are swallowed (we stays 0)
   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      sel_d   = sel_q;
      if (a_ready) begin
         we_d    = (a_addr != '0);
         waddr_d = a_addr;
         wdata_d = a_data;
         sel_d   = SRC_A;
      end else if (b_ready) begin
         we_d    = (b_addr != '0);
         waddr_d = b_addr;
         wdata_d = b_data;
         sel_d   = SRC_B;
      end
   end

   // Contention counter: clear wins, otherwise saturating increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (a_valid && b_valid && !stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Write port and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         sel_q   <= SRC_A;
         cnt_q   <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rf_we        = we_q;
   assign rf_waddr     = waddr_q;
   assign rf_wdata     = wdata_q;
   assign mux_sel      = sel_q;
   assign conflict_cnt = cnt_q;

endmodule
